// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer built around a single shared full-adder cell.
// Operands are walked through the cell LSB first, one bit per clock, with a
// registered carry; results are returned with a one-cycle done pulse.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sub_q, sub_d;
    logic              c_q, c_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    // Shared full-adder cell: the only adder logic in the block.
    logic fa_a, fa_b, fa_s, fa_co;

    // Full-adder cell fed from the operand LSBs and the registered carry.
    always_comb begin
        fa_a  = a_q[0];
        fa_b  = b_q[0] ^ sub_q;
        fa_s  = fa_a ^ fa_b ^ c_q;
        fa_co = (fa_a & fa_b) | (c_q & (fa_a ^ fa_b));
    end

    // Next-state logic: capture on start, shift one bit per RUN cycle, pulse DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    sub_d   = sub_i;
                    // Subtract is a + ~b + 1, so cin is ignored and forced high.
                    c_d     = sub_i | cin_i;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Cell sum enters at the MSB so the result lands aligned after WIDTH shifts.
                sum_d = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_co;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    cout_d  = fa_co;
                    // c_q is the carry into the MSB on this final step.
                    ovf_d   = c_q ^ fa_co;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Status and result outputs decoded straight from registers.
    always_comb begin
        busy_o = (state_q == StRun);
        done_o = (state_q == StDone);
        sum_o  = sum_q;
        cout_o = cout_q;
        ovf_o  = ovf_q;
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: an arithmetic reference model pushes the
// expected result at each accepting edge; a monitor pops and compares on done.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i, sub_i, cin_i;
    logic [W-1:0] a_i, b_i;
    logic         busy_o, done_o, cout_o, ovf_o;
    logic [W-1:0] sum_o;

    int   checks   = 0;
    int   failures = 0;
    int   accepts  = 0;
    int   dones    = 0;
    int   ph       = 0;   // 0 idle, 1..W running, W+1 done
    exp_t q[$];
    exp_t last;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .sub_i   (sub_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: unsigned sum for result/carry, signed sum for overflow.
    function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sub, input logic cin);
        exp_t   r;
        longint full = longint'(1) << W;
        longint half = longint'(1) << (W - 1);
        longint ua   = longint'(a);
        longint ub   = sub ? (full - 1 - longint'(b)) : longint'(b);
        longint c    = sub ? 1 : longint'(cin);
        longint tot  = ua + ub + c;
        longint sa   = (ua >= half) ? ua - full : ua;
        longint sb   = (ub >= half) ? ub - full : ub;
        longint st   = sa + sb + c;
        r.s  = W'(tot % full);
        r.co = (tot >= full);
        r.ov = (st >= half) || (st < -half);
        return r;
    endfunction

    // Reference timing model: accept when idle, W run cycles, one done cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            if (ph >= 1 && ph <= W) accepts <= accepts - 1;
            ph <= 0;
            q.delete();
        end else if (ph == 0) begin
            if (start_i) begin
                q.push_back(ref_op(a_i, b_i, sub_i, cin_i));
                accepts <= accepts + 1;
                ph      <= 1;
            end
        end else if (ph == W + 1) begin
            ph <= 0;
        end else begin
            ph <= ph + 1;
        end
    end

    // Monitor: status every cycle, results on done, held results while idle.
    always @(negedge clk) begin
        if (rst) begin
            last = '0;
        end else begin
            chk("busy", 32'(busy_o), 32'(ph >= 1 && ph <= W));
            chk("done", 32'(done_o), 32'(ph == W + 1));
            if (done_o) begin
                dones++;
                if (q.size() == 0) begin
                    chk("done_without_request", 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", 32'(sum_o), 32'(e.s));
                    chk("cout", 32'(cout_o), 32'(e.co));
                    chk("ovf", 32'(ovf_o), 32'(e.ov));
                    last = e;
                end
            end else if (ph == 0) begin
                chk("held_sum", 32'(sum_o), 32'(last.s));
                chk("held_cout", 32'(cout_o), 32'(last.co));
                chk("held_ovf", 32'(ovf_o), 32'(last.ov));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic c);
        int n = 0;
        @(negedge clk);
        while (ph != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'(1), 32'(0));
        a_i     = a;
        b_i     = b;
        sub_i   = s;
        cin_i   = c;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        // Scramble operands after acceptance; they must have no effect.
        a_i     = W'($urandom);
        b_i     = W'($urandom);
        sub_i   = 1'($urandom);
        cin_i   = 1'($urandom);
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        sub_i   = 1'b0;
        cin_i   = 1'b0;
        a_i     = '0;
        b_i     = '0;
        last    = '0;
        #1;
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        chk("rst_sum", 32'(sum_o), 32'(0));
        chk("rst_cout", 32'(cout_o), 32'(0));
        chk("rst_ovf", 32'(ovf_o), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the arithmetic corners.
        issue(8'h3C, 8'h0F, 1'b0, 1'b0);
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        issue(8'h05, 8'h07, 1'b1, 1'b0);
        issue(8'h80, 8'h01, 1'b1, 1'b0);
        issue(8'hFF, 8'hFF, 1'b0, 1'b1);
        issue(8'h00, 8'h00, 1'b1, 1'b1);

        // start held high with operands changing every cycle.
        @(negedge clk);
        start_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a_i   = W'($urandom);
            b_i   = W'($urandom);
            sub_i = 1'($urandom);
            cin_i = 1'($urandom);
            @(negedge clk);
        end
        start_i = 1'b0;

        // Asynchronous reset between edges at count=3.
        issue(8'h3C, 8'h0F, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy_o), 32'(0));
        chk("midrst_done", 32'(done_o), 32'(0));
        chk("midrst_sum", 32'(sum_o), 32'(0));
        chk("midrst_cout", 32'(cout_o), 32'(0));
        chk("midrst_ovf", 32'(ovf_o), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(8'h01, 8'h01, 1'b0, 1'b0);

        // Randomized add/subtract mix.
        for (int i = 0; i < 500; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        begin
            int n = 0;
            while ((ph != 0 || q.size() != 0) && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) chk("drain_timeout", 32'(1), 32'(0));
        end
        @(negedge clk);
        chk("done_count", 32'(dones), 32'(accepts));
        chk("queue_empty", 32'(q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Sequencer that time-shares a single 1-bit full-adder cell to perform WIDTH-bit add or subtract, one bit per clock, LSB first. It accepts a start/operand handshake, walks the operands through the shared cell with a registered carry, and returns sum, carry-out and signed overflow with a one-cycle done pulse. It is the area-minimal arithmetic option in the adders group, wrapping the existing full-adder cell.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b+cin, 1 = a-b (b inverted, carry-in forced 1, cin ignored); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
cin  input  1  carry-in for add; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: results valid
sum  output  WIDTH  result, registered
cout  output  1  carry out of MSB (sub: 1 = no borrow)
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- One instance of the existing full-adder cell; inputs are areg[0], breg[0] (XOR sub), creg; no other adder logic.
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal areg, breg, creg, count cleared. Takes effect immediately, including mid-RUN; the operation in flight is discarded, with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1: areg<=a, breg<=b, subreg<=sub, creg<=(sub ? 1 : cin), count<=0, state<=RUN. busy rises on the same edge. start=0: remain in IDLE.
- RUN, each edge:
  - sum shifts right with the cell sum entering at sum[WIDTH-1].
  - areg/breg shift right; creg<=cell carry; count<=count+1.
  - At count==WIDTH-1: cout<=cell carry, ovf<=creg XOR cell carry, state<=DONE.
- DONE: busy=0, done=1 for exactly one cycle; next edge -> IDLE.
- sum, cout and ovf are held from DONE until the next accepted start. They are not cleared in IDLE.
- sum is cleared on the accepting edge; partial values are visible during RUN and carry no meaning.
- Latency: accepting edge E0; RUN occupies edges E1..EWIDTH; done is high in the cycle after EWIDTH. The next start can be accepted at edge EWIDTH+2.
- start while busy or in DONE is ignored, not queued. Operand changes after E0 have no effect.
- WIDTH=1: a single RUN edge; ovf = cin XOR cout.
- count width = clog2(WIDTH) with a minimum of 1. No arithmetic wraps beyond WIDTH; the carry out of the MSB appears only on cout.

Test Plan:
- Reset, then add a=0x3C, b=0x0F, cin=0 (WIDTH=8) -> busy high for 8 cycles; done pulses in cycle 9 after the accepting edge; sum=0x4B, cout=0, ovf=0.
- Add a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Add a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- Subtract a=0x05, b=0x07 with cin=0 (must be ignored) -> sum=0xFE, cout=0, ovf=0. Subtract a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Hold start=1 continuously with changing a/b -> operations accepted only at IDLE edges, spaced WIDTH+2 cycles apart; each result matches the operands present at its own accepting edge.
- Assert rst asynchronously (between edges) at count=3 of a 0x3C+0x0F op -> outputs 0 immediately; no done pulse; the following start of 0x01+0x01 gives sum=0x02.
- Randomized 500 ops with add/sub mix against a reference model: sum, cout and ovf match; done count equals start-accept count.
